// File: rtl/tick_period_meter.sv
// tick_period_meter: measures clock_in cycles between rising edges of a tick train,
// reporting each completed period over valid/ready with saturation and overrun flags.
module tick_period_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             saturated,
    output logic             overrun
);
    typedef enum logic {ARM, MEASURE} state_t;
    state_t           state, state_d;
    logic             s, prev, rise;
    logic [WIDTH-1:0] count, count_d, period_d;
    logic             valid_d, sat_d, overrun_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = pulse_in;
        end else begin : g_sync
            // preset high so a level already present at reset release is not an edge
            logic [SYNC_STAGES-1:0] sync;
            always_ff @(posedge clock_in or posedge reset)
                if (reset) sync <= '1;
                else sync <= SYNC_STAGES'({sync, pulse_in});
            assign s = sync[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clock_in or posedge reset)
        if (reset) prev <= 1'b1;
        else prev <= s;

    assign rise = s & ~prev;

    always_comb begin
        state_d   = state;
        count_d   = count;
        period_d  = period;
        sat_d     = saturated;
        valid_d   = period_valid & ~period_ready;
        overrun_d = overrun;
        if (state == ARM) begin
            if (rise) begin
                state_d = MEASURE;
                count_d = WIDTH'(1);
            end
        end else if (rise) begin
            period_d  = count;
            sat_d     = &count;
            valid_d   = 1'b1;
            overrun_d = overrun | (period_valid & ~period_ready);
            count_d   = WIDTH'(1);
        end else begin
            count_d = (&count) ? count : count + WIDTH'(1);
        end
    end

    always_ff @(posedge clock_in or posedge reset)
        if (reset) begin
            state        <= ARM;
            count        <= '0;
            period       <= '0;
            saturated    <= 1'b0;
            period_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_d;
            count        <= count_d;
            period       <= period_d;
            saturated    <= sat_d;
            period_valid <= valid_d;
            overrun      <= overrun_d;
        end
endmodule
